// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_pkg
// Brief    : Shared width codes, FSM state encodings and byte-enable base masks
//            for the EX/MEM memory access unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BEAT0 = 2'd1;
    localparam logic [1:0] c_ST_BEAT1 = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    localparam logic [3:0] c_BE_BASE_B = 4'b0001;
    localparam logic [3:0] c_BE_BASE_H = 4'b0011;
    localparam logic [3:0] c_BE_BASE_W = 4'b1111;

    // Width code 2'b11 behaves as a word access.
    function automatic logic [3:0] be_base(input logic [1:0] width);
        case (width)
            MEM_B:   be_base = c_BE_BASE_B;
            MEM_H:   be_base = c_BE_BASE_H;
            default: be_base = c_BE_BASE_W;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
//------------------------------------------------------------------------------
// Module   : mem_lane_align
// Brief    : Combinational lane steering: beat0/beat1 byte enables and store
//            data, plus load extraction with sign/zero extension.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_width,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wdata0,
    output logic [31:0] o_wdata1,
    input  logic [1:0]  i_ext_off,
    input  logic [1:0]  i_ext_width,
    input  logic        i_ext_sign,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_be_wide;
    logic [63:0] w_wdata_wide;
    logic [31:0] w_word;

    // Shifting across a 2-word window yields beat1 as the spill-over half.
    assign w_be_wide    = {4'b0000, be_base(i_width)} << i_off;
    assign w_wdata_wide = {32'h0000_0000, i_wdata} << {i_off, 3'b000};

    assign o_be0    = w_be_wide[3:0];
    assign o_be1    = w_be_wide[7:4];
    assign o_wdata0 = w_wdata_wide[31:0];
    assign o_wdata1 = w_wdata_wide[63:32];

    assign w_word = 32'({i_hi, i_lo} >> {i_ext_off, 3'b000});

    always_comb begin
        o_rdata = w_word;
        case (i_ext_width)
            MEM_B:   o_rdata = {{24{i_ext_sign & w_word[7]}},  w_word[7:0]};
            MEM_H:   o_rdata = {{16{i_ext_sign & w_word[15]}}, w_word[15:0]};
            default: o_rdata = w_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit
// Brief    : EX/MEM consumer performing loads/stores over a req/ack word bus,
//            stalling the pipeline until done. Optional two-beat misaligned
//            accesses under macro MEM_MISALIGN_SPLIT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              mem_write_i,
    input  logic [1:0]        mem_width_i,
    input  logic              mem_sign_extend_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);

    localparam int unsigned c_CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [1:0]        r_state;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wdata;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]        r_off;
    logic [1:0]        r_width;
    logic              r_sign;
    logic              r_we;

    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [31:0]       w_wdata0;
    logic [31:0]       w_wdata1;
    logic [31:0]       w_lo;
    logic [31:0]       w_hi;
    logic [31:0]       w_rdata_ext;
    logic [ADDR_W-1:0] w_addr0;
    logic              w_split;
    logic              w_timeout;
    logic              w_to_beat1;

    assign w_addr0 = {addr_i[ADDR_W-1:2], 2'b00};
    assign w_split = |w_be1;
    assign stall_o = valid_i && (r_state != c_ST_RESP);

    mem_lane_align u_align (
        .i_off       (addr_i[1:0]),
        .i_width     (mem_width_i),
        .i_wdata     (wdata_i),
        .o_be0       (w_be0),
        .o_be1       (w_be1),
        .o_wdata0    (w_wdata0),
        .o_wdata1    (w_wdata1),
        .i_ext_off   (r_off),
        .i_ext_width (r_width),
        .i_ext_sign  (r_sign),
        .i_lo        (w_lo),
        .i_hi        (w_hi),
        .o_rdata     (w_rdata_ext)
    );

    generate
        if (MAX_WAIT > 0) begin : g_timeout
            assign w_timeout = (r_cnt == c_CNT_W'(MAX_WAIT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

`ifdef MEM_MISALIGN_SPLIT_EN
    logic        r_split;
    logic [31:0] r_lo;

    assign w_to_beat1 = (r_state == c_ST_BEAT0) && r_split && bus_ack_i;

    // The final beat of a split load supplies the upper word of the window.
    always_comb begin
        w_lo = bus_rdata_i;
        w_hi = 32'h0000_0000;
        if (r_state == c_ST_BEAT1) begin
            w_lo = r_lo;
            w_hi = bus_rdata_i;
        end
    end
`else
    logic w_unused_wdata1;

    assign w_unused_wdata1 = ^w_wdata1;
    assign w_to_beat1      = 1'b0;

    always_comb begin
        w_lo = bus_rdata_i;
        w_hi = 32'h0000_0000;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_cnt       <= '0;
            r_off       <= 2'b00;
            r_width     <= MEM_B;
            r_sign      <= 1'b0;
            r_we        <= 1'b0;
`ifdef MEM_MISALIGN_SPLIT_EN
            r_split     <= 1'b0;
            r_lo        <= 32'h0000_0000;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (valid_i) begin
                        r_off   <= addr_i[1:0];
                        r_width <= mem_width_i;
                        r_sign  <= mem_sign_extend_i;
                        r_we    <= mem_write_i;
                        r_cnt   <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
                        r_split     <= w_split;
                        r_state     <= c_ST_BEAT0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_write_i;
                        r_bus_addr  <= w_addr0;
                        r_bus_be    <= w_be0;
                        r_bus_wdata <= w_wdata0;
`else
                        // Misaligned-across-word accesses are rejected without touching the bus.
                        if (w_split) begin
                            r_state <= c_ST_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= 32'h0000_0000;
                        end else begin
                            r_state     <= c_ST_BEAT0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write_i;
                            r_bus_addr  <= w_addr0;
                            r_bus_be    <= w_be0;
                            r_bus_wdata <= w_wdata0;
                        end
`endif
                    end
                end
                c_ST_BEAT0, c_ST_BEAT1: begin
                    if (w_to_beat1) begin
                        r_cnt <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
                        r_lo        <= bus_rdata_i;
                        r_state     <= c_ST_BEAT1;
                        r_bus_addr  <= r_bus_addr + ADDR_W'(4);
                        r_bus_be    <= w_be1;
                        r_bus_wdata <= w_wdata1;
`endif
                    end else if (bus_ack_i) begin
                        r_cnt     <= '0;
                        r_state   <= c_ST_RESP;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_rdata   <= r_we ? 32'h0000_0000 : w_rdata_ext;
                    end else if (w_timeout) begin
                        r_cnt     <= '0;
                        r_state   <= c_ST_RESP;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_rdata   <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    r_rdata <= 32'h0000_0000;
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign done_o      = r_done;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_be_o    = r_bus_be;
    assign bus_wdata_o = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access_unit
// Brief    : Directed scoreboard bench for mem_access_unit with a req/ack bus
//            slave; follows MEM_MISALIGN_SPLIT_EN for the split cases.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        mem_write_i;
    logic [1:0]  mem_width_i;
    logic        mem_sign_extend_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } result_t;

    beat_t   beat_q[$];
    result_t res_q[$];
    int      n_checks;
    int      n_errors;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_i           (valid_i),
        .mem_write_i       (mem_write_i),
        .mem_width_i       (mem_width_i),
        .mem_sign_extend_i (mem_sign_extend_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .stall_o           (stall_o),
        .done_o            (done_o),
        .rdata_o           (rdata_o),
        .err_o             (err_o),
        .bus_req_o         (bus_req_o),
        .bus_we_o          (bus_we_o),
        .bus_addr_o        (bus_addr_o),
        .bus_be_o          (bus_be_o),
        .bus_wdata_o       (bus_wdata_o),
        .bus_ack_i         (bus_ack_i),
        .bus_rdata_i       (bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd, input logic we, input logic [31:0] rd);
        beat_t b;
        b.addr  = a;
        b.be    = be;
        b.wdata = wd;
        b.we    = we;
        b.rdata = rd;
        beat_q.push_back(b);
    endtask

    // Drives one op, plays the bus slave (first beat acked after 'delay'
    // waits), and scores the completion popped from the result queue.
    task automatic access(input string tag, input logic we, input logic [1:0] width,
                          input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                          input int delay, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_cycle);
        result_t r;
        beat_t   cur;
        int      cyc;
        int      waited;
        int      stalls;
        int      cur_delay;
        bit      in_beat;
        bit      first;
        bit      done_seen;

        r.rdata = exp_rdata;
        r.err   = exp_err;
        r.cycle = exp_cycle;
        res_q.push_back(r);

        @(posedge clk);
        #1;
        valid_i           = 1'b1;
        mem_write_i       = we;
        mem_width_i       = width;
        mem_sign_extend_i = sgn;
        addr_i            = a;
        wdata_i           = wd;
        bus_ack_i         = 1'b0;

        cyc       = 1;
        waited    = 0;
        stalls    = 0;
        cur_delay = 0;
        in_beat   = 1'b0;
        first     = 1'b1;
        done_seen = 1'b0;
        cur       = '{32'h0, 4'h0, 32'h0, 1'b0, 32'h0};

        while (!done_seen && cyc <= 40) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done_o) begin
                done_seen = 1'b1;
                bus_ack_i = 1'b0;
                r = res_q.pop_front();
                check({tag, ":rdata"},      rdata_o, r.rdata);
                check({tag, ":err"},        {31'b0, err_o}, {31'b0, r.err});
                check({tag, ":done_cycle"}, 32'(cyc), 32'(r.cycle));
                check({tag, ":stall_cnt"},  32'(stalls), 32'(r.cycle - 1));
                check({tag, ":stall_done"}, {31'b0, stall_o}, 32'd0);
                check({tag, ":req_done"},   {31'b0, bus_req_o}, 32'd0);
            end else if (bus_req_o) begin
                if (!in_beat) begin
                    check({tag, ":beat_expected"}, {31'b0, beat_q.size() != 0}, 32'd1);
                    if (beat_q.size() != 0) cur = beat_q.pop_front();
                    in_beat   = 1'b1;
                    waited    = 0;
                    cur_delay = first ? delay : 0;
                end
                check({tag, ":bus_addr"},  bus_addr_o, cur.addr);
                check({tag, ":bus_be"},    {28'b0, bus_be_o}, {28'b0, cur.be});
                check({tag, ":bus_wdata"}, bus_wdata_o, cur.wdata);
                check({tag, ":bus_we"},    {31'b0, bus_we_o}, {31'b0, cur.we});
                if (waited >= cur_delay) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = cur.rdata;
                    in_beat     = 1'b0;
                    first       = 1'b0;
                end else begin
                    bus_ack_i   = 1'b0;
                    bus_rdata_i = $urandom();
                    waited++;
                end
            end else begin
                bus_ack_i = 1'b0;
            end
            cyc++;
        end
        check({tag, ":done_seen"},  {31'b0, done_seen}, 32'd1);
        check({tag, ":beats_left"}, 32'(beat_q.size()), 32'd0);
        beat_q.delete();

        @(posedge clk);
        #1;
        valid_i   = 1'b0;
        bus_ack_i = 1'b0;
        @(negedge clk);
        check({tag, ":done_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b1;
        valid_i           = 1'b0;
        mem_write_i       = 1'b0;
        mem_width_i       = MEM_W;
        mem_sign_extend_i = 1'b0;
        addr_i            = 32'h0;
        wdata_i           = 32'h0;
        bus_ack_i         = 1'b0;
        bus_rdata_i       = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:req",   {31'b0, bus_req_o}, 32'd0);
        check("rst:we",    {31'b0, bus_we_o},  32'd0);
        check("rst:done",  {31'b0, done_o},    32'd0);
        check("rst:err",   {31'b0, err_o},     32'd0);
        check("rst:rdata", rdata_o,            32'd0);
        check("rst:addr",  bus_addr_o,         32'd0);
        check("rst:be",    {28'b0, bus_be_o},  32'd0);
        check("rst:wdata", bus_wdata_o,        32'd0);
        check("rst:stall", {31'b0, stall_o},   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        push_beat(32'h100, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF);
        access("lw_100", 1'b0, MEM_W, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 3);

        push_beat(32'h100, 4'b1000, 32'h0, 1'b0, 32'h80123456);
        access("lb_103", 1'b0, MEM_B, 1'b1, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0, 3);

        push_beat(32'h100, 4'b1000, 32'h0, 1'b0, 32'h80123456);
        access("lbu_103", 1'b0, MEM_B, 1'b0, 32'h103, 32'h0, 0, 32'h00000080, 1'b0, 3);

        push_beat(32'h200, 4'b1100, 32'hABCD0000, 1'b1, 32'h13579BDF);
        access("sh_202", 1'b1, MEM_H, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h0, 1'b0, 6);

        push_beat(32'h100, 4'b1100, 32'h0, 1'b0, 32'h9ABC0000);
        access("lh_102", 1'b0, MEM_H, 1'b1, 32'h102, 32'h0, 1, 32'hFFFF9ABC, 1'b0, 4);

        push_beat(32'h100, 4'b0010, 32'h00005A00, 1'b1, 32'h12345678);
        access("sb_101", 1'b1, MEM_B, 1'b0, 32'h101, 32'h0000005A, 0, 32'h0, 1'b0, 3);

        push_beat(32'h108, 4'b1111, 32'h0, 1'b0, 32'h0BADF00D);
        access("lw11_108", 1'b0, 2'b11, 1'b1, 32'h108, 32'h0, 0, 32'h0BADF00D, 1'b0, 3);

`ifdef MEM_MISALIGN_SPLIT_EN
        push_beat(32'h1FC, 4'b1100, 32'h0, 1'b0, 32'h11223344);
        push_beat(32'h200, 4'b0011, 32'h0, 1'b0, 32'h55667788);
        access("lw_1fe", 1'b0, MEM_W, 1'b0, 32'h1FE, 32'h0, 0, 32'h77881122, 1'b0, 4);

        push_beat(32'h200, 4'b1000, 32'h34000000, 1'b1, 32'hFFFFFFFF);
        push_beat(32'h204, 4'b0001, 32'h00000012, 1'b1, 32'hFFFFFFFF);
        access("sh_203", 1'b1, MEM_H, 1'b0, 32'h203, 32'h00001234, 2, 32'h0, 1'b0, 6);

        push_beat(32'hFFFFFFFC, 4'b1000, 32'h0, 1'b0, 32'hAB000000);
        push_beat(32'h00000000, 4'b0001, 32'h0, 1'b0, 32'h000000CD);
        access("lhu_wrap", 1'b0, MEM_H, 1'b0, 32'hFFFFFFFF, 32'h0, 0, 32'h0000CDAB, 1'b0, 4);
`else
        access("lw_1fe", 1'b0, MEM_W, 1'b0, 32'h1FE, 32'h0, 0, 32'h0, 1'b1, 2);
        access("sh_203", 1'b1, MEM_H, 1'b0, 32'h203, 32'h00001234, 0, 32'h0, 1'b1, 2);
        access("lhu_wrap", 1'b0, MEM_H, 1'b0, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 1'b1, 2);
`endif

        push_beat(32'h400, 4'b1111, 32'h0, 1'b0, 32'h76543210);
        access("lw_timeout", 1'b0, MEM_W, 1'b0, 32'h400, 32'h0, 1000, 32'h0, 1'b1, 6);

        // Reset while the first beat waits for an ack; stray acks afterwards.
        @(posedge clk);
        #1;
        valid_i           = 1'b1;
        mem_write_i       = 1'b0;
        mem_width_i       = MEM_W;
        mem_sign_extend_i = 1'b0;
        addr_i            = 32'h300;
        wdata_i           = 32'h0;
        bus_ack_i         = 1'b0;
        @(negedge clk);
        check("rst_mid:stall_idle", {31'b0, stall_o}, 32'd1);
        @(negedge clk);
        check("rst_mid:req_beat0", {31'b0, bus_req_o}, 32'd1);
        check("rst_mid:addr_beat0", bus_addr_o, 32'h300);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        valid_i     = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        check("rst_mid:req_dropped", {31'b0, bus_req_o}, 32'd0);
        check("rst_mid:no_done", {31'b0, done_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid:idle_done", {31'b0, done_o}, 32'd0);
            check("rst_mid:idle_req", {31'b0, bus_req_o}, 32'd0);
        end
        bus_ack_i = 1'b0;

        push_beat(32'h104, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D);
        access("lw_after_rst", 1'b0, MEM_W, 1'b0, 32'h104, 32'h0, 0, 32'hCAFEF00D, 1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer end of the EX/MEM pipeline latch. Takes the latched ALU result (address), rs2 data (store data), width, sign-extend and write controls.
- Performs the load or store on a word-wide data bus with a req/ack handshake.
- Returns aligned, extended load data toward MEM/WB.
- Holds the pipeline via stall_o until the access completes.

Parameters:
- ADDR_W, 32, byte-address width.
- MAX_WAIT, 0, bus timeout in cycles; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  memory op present in EX/MEM (load or store)
- mem_write_i  in  1  1=store, 0=load
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_sign_extend_i  in  1  sign-extend load result
- addr_i  in  ADDR_W  byte address (ALU result)
- wdata_i  in  32  store data, low-justified
- stall_o  out  1  hold EX/MEM and earlier stages
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load data, valid while done_o=1
- err_o  out  1  timeout, or misaligned access (see Optional Feature); valid with done_o
- bus_req_o  out  1  request
- bus_we_o  out  1  write enable
- bus_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0)
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-shifted write data
- bus_ack_i  in  1  request accepted/completed this cycle
- bus_rdata_i  in  32  read word, valid when bus_ack_i=1

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP.
- Reset: state IDLE. bus_req_o, bus_we_o, done_o, err_o = 0. rdata_o, bus_addr_o, bus_be_o, bus_wdata_o = 0. Timeout counter = 0.
- stall_o = valid_i && state!=RESP (combinational). Inputs are stable while stall_o=1; the pipeline advances on the edge where stall_o=0.
- IDLE:
  - If valid_i, capture address offset off=addr_i[1:0], width, sign and write controls.
  - Compute beat0 BE and data. Go to BEAT0 with bus_req_o=1.
- Byte enables:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111<<off
  - Bits shifted above bit 3 form the beat1 BE: (mask<<off)>>4.
- Write data:
  - beat0: wdata_i<<(8*off)
  - beat1: wdata_i>>(8*(4-off))
- Beat addresses: beat0 = {addr[ADDR_W-1:2],2'b00}; beat1 = beat0+4, wrapping modulo 2^ADDR_W.
- Split condition: beat1 BE != 0 (half at off=3; word at off!=0).
- BEAT0:
  - Hold bus_req_o and all bus outputs stable until bus_ack_i=1.
  - On the ack edge, save bus_rdata_i as lo.
  - If split, go to BEAT1 with req kept high, beat1 address/BE/data loaded on the same edge. Otherwise go to RESP.
- BEAT1: on ack, save hi, go to RESP.
- RESP:
  - bus_req_o=0, done_o=1, stall_o=0.
  - rdata_o = ({hi,lo}>>(8*off)), truncated to width, then sign- or zero-extended. hi=0 if not split.
  - Next state IDLE.
  - Stores: rdata_o=0.
- Latency: unsplit access with immediate ack = 3 cycles from valid_i to done_o. Each extra wait cycle adds 1; a split access adds 1.
- Timeout (MAX_WAIT>0): counter increments per unacked cycle in BEAT0/BEAT1. When it reaches MAX_WAIT, go to RESP with err_o=1 and rdata_o=0.
- Reset mid-transaction: bus_req_o drops the cycle after rst. The slave must tolerate an abandoned request. A split store may leave beat0 committed.
- bus_ack_i outside BEAT0/BEAT1 is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_SPLIT_EN.
- Defined: split accesses are performed as two beats as described above.
- Undefined:
  - A split-condition access issues no bus transaction. IDLE goes directly to RESP with err_o=1, rdata_o=0, no store side effect.
  - Latency is 2 cycles. BEAT1 state is absent.

Decomposition:
- Package mem_pkg:
  - width codes (MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10)
  - state enum
  - BE base masks per width
- Sub-module mem_lane_align (combinational): BE/wdata shift for both beats and load extract/extend.
- The FSM, captures and timeout counter stay in mem_access_unit.

Test Plan:
- Load word, addr=0x100, bus_rdata=0xDEADBEEF, ack on the first req cycle -> bus_addr=0x100, be=1111, done_o at cycle 3, rdata_o=0xDEADBEEF.
- Load byte signed, addr=0x103, rdata=0x80123456 -> be=1000, rdata_o=0xFFFFFF80. Same access unsigned -> rdata_o=0x00000080.
- Store half, addr=0x202, wdata=0x0000ABCD, ack delayed 3 cycles -> bus_addr=0x200, be=1100, bus_wdata=0xABCD0000 held stable. stall_o high 5 cycles, done_o on cycle 6.
- Split load word, addr=0x1FE, beats 0x11223344 then 0x55667788 (with macro) -> addrs 0x1FC then 0x200, BEs 1100 then 0011, rdata_o=0x77881122. Without macro -> no bus_req_o, err_o=1, done_o at cycle 2.
- rst asserted while in BEAT0 awaiting ack -> next cycle bus_req_o=0, state IDLE, done_o never pulses.
- MAX_WAIT=4, ack never asserted -> done_o and err_o=1 after 4 wait cycles, rdata_o=0.
